// File: rtl/sdram_arb_pkg.sv
// Shared constants for the SDRAM arbiter: command codes, owner codes, burst sizes
// and the arbiter state encoding.
package sdram_arb_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RDV = 2'b10;
  localparam logic [1:0] CMD_RDC = 2'b11;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WR   = 2'd1;
  localparam logic [1:0] OWN_VID  = 2'd2;
  localparam logic [1:0] OWN_RD   = 2'd3;

  localparam int VID_WORDS   = 19200;
  localparam int VID_PTR_W   = 19;
  localparam int VID_BEATS   = 16;
  localparam int CACHE_BEATS = 128;
  localparam int BEAT_W      = 8;
  localparam int STARVE_W    = 3;
  localparam logic [STARVE_W-1:0] STARVE_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vid_pack16to32.sv
// Packs pairs of 16-bit video read beats into 32-bit queue words,
// first beat in the low half.
module vid_pack16to32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        beat_valid,
  input  logic [15:0] beat_data,
  output logic [31:0] vq_data,
  output logic        vq_we
);

  logic        half;
  logic [15:0] low;

  always_ff @(posedge clk) begin
    if (!rst) begin
      half    <= 1'b0;
      low     <= '0;
      vq_data <= '0;
      vq_we   <= 1'b0;
    end else begin
      vq_we <= 1'b0;
      if (clear) begin
        half <= 1'b0;
      end else if (beat_valid) begin
        if (!half) begin
          low  <= beat_data;
          half <= 1'b1;
        end else begin
          vq_data <= {beat_data, low};
          vq_we   <= 1'b1;
          half    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM controller between video refill, cache writeback and cache
// fill; one burst at a time, command held until acked, beats counted to burst end.
module sdram_arbiter
  import sdram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_low,
  input  logic        vid_restart,
  input  logic        cache_wr_req,
  input  logic [16:0] cache_waddr,
  input  logic        cache_rd_req,
  input  logic [16:0] cache_raddr,
  output logic [1:0]  sys_cmd,
  output logic [22:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_fill_we,
  output logic        cache_drain_re,
  output logic [31:0] vq_data,
  output logic        vq_we,
  output logic [1:0]  owner,
  output logic        busy,
  output arb_state_t  state_dbg
);

  arb_state_t state, state_nxt;

  logic [VID_PTR_W-1:0] vid_ptr, ptr_eff;
  logic [STARVE_W-1:0]  starve;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 restart_pend;
  logic cache_req, grant_vid, grant_wr, grant_rd, ack_hit, beat, last_beat;

  always_comb begin
    cache_req = cache_wr_req | cache_rd_req;
    ptr_eff   = restart_pend ? '0 : vid_ptr;
    grant_vid = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    if (state == ST_IDLE) begin
      if (vid_low && (starve < STARVE_MAX || !cache_req)) grant_vid = 1'b1;
      else if (cache_wr_req)                              grant_wr  = 1'b1;
      else if (cache_rd_req)                              grant_rd  = 1'b1;
    end
    ack_hit   = (state == ST_ISSUE) && (sys_cmd_ack == sys_cmd);
    // Beats only count in XFER and only with an owner; stray valids are dropped.
    beat      = (state == ST_XFER) && (owner != OWN_NONE) &&
                ((owner == OWN_WR) ? sys_wr_data_valid : sys_rd_data_valid);
    last_beat = beat && (beat_cnt == ((owner == OWN_VID) ? BEAT_W'(VID_BEATS - 1)
                                                         : BEAT_W'(CACHE_BEATS - 1)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_vid || grant_wr || grant_rd) state_nxt = ST_ISSUE;
      ST_ISSUE: if (ack_hit)                           state_nxt = ST_XFER;
      ST_XFER:  if (last_beat)                         state_nxt = ST_IDLE;
      default:                                         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner        <= OWN_NONE;
      sys_cmd      <= CMD_NOP;
      sys_addr     <= '0;
      vid_ptr      <= '0;
      starve       <= '0;
      beat_cnt     <= '0;
      restart_pend <= 1'b0;
    end else begin
      // A restart is applied at the next IDLE cycle so an in-flight burst keeps its address.
      restart_pend <= vid_restart | (restart_pend & (state != ST_IDLE));
      if (state == ST_IDLE && restart_pend) vid_ptr <= '0;

      if (grant_vid) begin
        owner    <= OWN_VID;
        sys_cmd  <= CMD_RDV;
        sys_addr <= {1'b1, ptr_eff, 3'b000};
        beat_cnt <= '0;
        if (cache_req && starve < STARVE_MAX) starve <= starve + 1'b1;
      end else if (grant_wr) begin
        owner    <= OWN_WR;
        sys_cmd  <= CMD_WR;
        sys_addr <= {cache_waddr, 6'b000000};
        beat_cnt <= '0;
        starve   <= '0;
      end else if (grant_rd) begin
        owner    <= OWN_RD;
        sys_cmd  <= CMD_RDC;
        sys_addr <= {cache_raddr, 6'b000000};
        beat_cnt <= '0;
        starve   <= '0;
      end

      if (ack_hit) begin
        sys_cmd <= CMD_NOP;
        if (owner == OWN_VID)
          vid_ptr <= (vid_ptr == VID_PTR_W'(VID_WORDS - 1)) ? '0 : vid_ptr + 1'b1;
      end

      if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (last_beat) owner <= OWN_NONE;
      end
    end
  end

  assign cache_fill_we  = sys_rd_data_valid && (owner == OWN_RD);
  assign cache_drain_re = sys_wr_data_valid && (owner == OWN_WR);
  assign busy           = (state != ST_IDLE);
  assign state_dbg      = state;

  vid_pack16to32 u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (grant_vid),
    .beat_valid (beat && (owner == OWN_VID)),
    .beat_data  (sys_dout),
    .vq_data    (vq_data),
    .vq_we      (vq_we)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a small SDRAM responder task plus one task per
// scenario, each comparing observed outputs with hand-computed values.
module tb_sdram_arbiter;

  logic        clk;
  logic        rst;
  logic        vid_low;
  logic        vid_restart;
  logic        cache_wr_req;
  logic [16:0] cache_waddr;
  logic        cache_rd_req;
  logic [16:0] cache_raddr;
  logic [1:0]  sys_cmd;
  logic [22:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid;
  logic        sys_wr_data_valid;
  logic [15:0] sys_dout;
  logic        cache_fill_we;
  logic        cache_drain_re;
  logic [31:0] vq_data;
  logic        vq_we;
  logic [1:0]  owner;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks;
  int errors;
  int fill_cnt;
  int drain_cnt;
  int vqwe_cnt;
  logic [31:0] vq_obs[$];
  logic [31:0] exp_q[$];

  sdram_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .vid_low           (vid_low),
    .vid_restart       (vid_restart),
    .cache_wr_req      (cache_wr_req),
    .cache_waddr       (cache_waddr),
    .cache_rd_req      (cache_rd_req),
    .cache_raddr       (cache_raddr),
    .sys_cmd           (sys_cmd),
    .sys_addr          (sys_addr),
    .sys_cmd_ack       (sys_cmd_ack),
    .sys_rd_data_valid (sys_rd_data_valid),
    .sys_wr_data_valid (sys_wr_data_valid),
    .sys_dout          (sys_dout),
    .cache_fill_we     (cache_fill_we),
    .cache_drain_re    (cache_drain_re),
    .vq_data           (vq_data),
    .vq_we             (vq_we),
    .owner             (owner),
    .busy              (busy),
    .state_dbg         (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Strobe monitor on the falling edge
  always @(negedge clk) begin
    if (cache_fill_we)  fill_cnt++;
    if (cache_drain_re) drain_cnt++;
    if (vq_we) begin
      vqwe_cnt++;
      vq_obs.push_back(vq_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    fill_cnt  = 0;
    drain_cnt = 0;
    vqwe_cnt  = 0;
    vq_obs.delete();
    exp_q.delete();
  endtask

  // Waits for a command, acks it after ack_dly cycles, then delivers the burst beats
  // (data 1..n). vid_restart pulses with beat restart_at when restart_at > 0.
  task automatic serve(input int ack_dly, input int restart_at,
                       output logic [1:0] got_cmd, output logic [22:0] got_addr,
                       output logic timeout);
    int t;
    int nb;
    t        = 0;
    timeout  = 1'b0;
    got_cmd  = 2'b00;
    got_addr = '0;
    while (sys_cmd == 2'b00 && t < 60) begin
      tick();
      t++;
    end
    if (sys_cmd == 2'b00) begin
      timeout = 1'b1;
      return;
    end
    got_cmd  = sys_cmd;
    got_addr = sys_addr;
    repeat (ack_dly) tick();
    sys_cmd_ack = got_cmd;
    tick();
    sys_cmd_ack = 2'b00;
    nb = (got_cmd == 2'b10) ? 16 : 128;
    for (int i = 1; i <= nb; i++) begin
      if (got_cmd == 2'b01) sys_wr_data_valid = 1'b1;
      else                  sys_rd_data_valid = 1'b1;
      sys_dout    = 16'(i);
      vid_restart = (i == restart_at);
      tick();
    end
    sys_wr_data_valid = 1'b0;
    sys_rd_data_valid = 1'b0;
    vid_restart       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (sys_cmd !== 2'b00) begin errors++; $display("FAIL reset_cmd: got %h expected 0", sys_cmd); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %h expected 0", owner); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (vq_we !== 1'b0 || vq_data !== 32'h0) begin errors++; $display("FAIL reset_vq: got we=%b data=%h expected 0/0", vq_we, vq_data); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    checks++; if (dut.vid_ptr !== 19'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.vid_ptr); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_video();
    logic [1:0]  c;
    logic [22:0] a;
    logic        to;
    int t;
    int bad;
    clear_counts();
    for (int k = 0; k < 8; k++) exp_q.push_back({16'(2 * k + 2), 16'(2 * k + 1)});
    vid_low = 1'b1;
    t = 0;
    while (sys_cmd == 2'b00 && t < 20) begin tick(); t++; end
    vid_low = 1'b0;
    checks++; if (sys_cmd !== 2'b10) begin errors++; $display("FAIL vid_cmd: got %h expected 2", sys_cmd); end
    checks++; if (sys_addr !== 23'h400000) begin errors++; $display("FAIL vid_addr: got %h expected 400000", sys_addr); end
    checks++; if (owner !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL vid_grant: got owner=%0d busy=%b expected 2/1", owner, busy); end
    // Ack carrying a different code must not be taken
    sys_cmd_ack = 2'b11;
    tick();
    sys_cmd_ack = 2'b00;
    checks++; if (sys_cmd !== 2'b10 || state_dbg !== 2'd1) begin errors++; $display("FAIL wrong_ack: got cmd=%h state=%0d expected 2/1", sys_cmd, state_dbg); end
    serve(2, 0, c, a, to);
    tick();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL vid_timeout: got %b expected 0", to); end
    checks++; if (vqwe_cnt !== 8) begin errors++; $display("FAIL vid_vqwe_cnt: got %0d expected 8", vqwe_cnt); end
    checks++; if (vq_obs.size() < 1 || vq_obs[0] !== 32'h00020001) begin errors++; $display("FAIL vid_first_word: got %h expected 00020001", (vq_obs.size() > 0) ? vq_obs[0] : 32'hx); end
    bad = 0;
    for (int k = 0; k < 8; k++) if (k >= vq_obs.size() || vq_obs[k] !== exp_q[k]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL vid_words: got %0d wrong words expected 0", bad); end
    checks++; if (owner !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL vid_end: got owner=%0d busy=%b expected 0/0", owner, busy); end
    checks++; if (dut.vid_ptr !== 19'd1) begin errors++; $display("FAIL vid_ptr: got %0d expected 1", dut.vid_ptr); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  c;
    logic [22:0] a;
    logic        to;
    clear_counts();
    cache_waddr  = 17'h00012;
    cache_raddr  = 17'h00034;
    cache_wr_req = 1'b1;
    cache_rd_req = 1'b1;
    serve(1, 0, c, a, to);
    cache_wr_req = 1'b0;
    checks++; if (to !== 1'b0 || c !== 2'b01) begin errors++; $display("FAIL wr_cmd: got %h timeout=%b expected 1", c, to); end
    checks++; if (a !== 23'h000480) begin errors++; $display("FAIL wr_addr: got %h expected 000480", a); end
    checks++; if (drain_cnt !== 128 || fill_cnt !== 0) begin errors++; $display("FAIL wr_strobes: got drain=%0d fill=%0d expected 128/0", drain_cnt, fill_cnt); end
    serve(0, 0, c, a, to);
    cache_rd_req = 1'b0;
    checks++; if (to !== 1'b0 || c !== 2'b11) begin errors++; $display("FAIL rd_cmd: got %h timeout=%b expected 3", c, to); end
    checks++; if (a !== 23'h000D00) begin errors++; $display("FAIL rd_addr: got %h expected 000d00", a); end
    checks++; if (fill_cnt !== 128 || drain_cnt !== 128) begin errors++; $display("FAIL rd_strobes: got fill=%0d drain=%0d expected 128/128", fill_cnt, drain_cnt); end
    tick();
  endtask

  task automatic test_starve();
    logic [1:0]  c;
    logic [22:0] a;
    logic        to;
    int nvid;
    int bad_addr;
    logic seen_rd;
    nvid     = 0;
    bad_addr = 0;
    seen_rd  = 1'b0;
    cache_raddr  = 17'h00034;
    vid_low      = 1'b1;
    cache_rd_req = 1'b1;
    for (int b = 0; b < 6 && !seen_rd; b++) begin
      serve(0, 0, c, a, to);
      if (to) break;
      if (c == 2'b11) seen_rd = 1'b1;
      else begin
        // Pointer was 1 after the first video burst
        if (a !== (23'h400000 | 23'((nvid + 1) * 8))) bad_addr++;
        nvid++;
      end
    end
    vid_low      = 1'b0;
    cache_rd_req = 1'b0;
    checks++; if (nvid !== 4) begin errors++; $display("FAIL starve_vid_count: got %0d expected 4", nvid); end
    checks++; if (seen_rd !== 1'b1) begin errors++; $display("FAIL starve_rd_granted: got %b expected 1", seen_rd); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL starve_vid_addr: got %0d wrong expected 0", bad_addr); end
    checks++; if (dut.starve !== 3'd0) begin errors++; $display("FAIL starve_cleared: got %0d expected 0", dut.starve); end
    tick();
  endtask

  task automatic test_wrap();
    logic [1:0]  c;
    logic [22:0] a;
    logic        to;
    tick();
    force dut.vid_ptr = 19'd19198;
    tick();
    release dut.vid_ptr;
    tick();
    checks++; if (dut.vid_ptr !== 19'd19198) begin errors++; $display("FAIL wrap_preload: got %0d expected 19198", dut.vid_ptr); end
    vid_low = 1'b1;
    serve(0, 0, c, a, to);
    checks++; if (to !== 1'b0 || a !== 23'h4257F0) begin errors++; $display("FAIL wrap_addr0: got %h expected 4257f0", a); end
    serve(0, 0, c, a, to);
    vid_low = 1'b0;
    checks++; if (to !== 1'b0 || a !== 23'h4257F8) begin errors++; $display("FAIL wrap_addr1: got %h expected 4257f8", a); end
    checks++; if (dut.vid_ptr !== 19'd0) begin errors++; $display("FAIL wrap_ptr: got %0d expected 0", dut.vid_ptr); end
    tick();
  endtask

  task automatic test_reset_mid();
    int t;
    clear_counts();
    cache_raddr  = 17'h00056;
    cache_rd_req = 1'b1;
    t = 0;
    while (sys_cmd == 2'b00 && t < 20) begin tick(); t++; end
    cache_rd_req = 1'b0;
    checks++; if (sys_cmd !== 2'b11) begin errors++; $display("FAIL rmid_cmd: got %h expected 3", sys_cmd); end
    sys_cmd_ack = 2'b11;
    tick();
    sys_cmd_ack = 2'b00;
    for (int i = 1; i < 50; i++) begin
      sys_rd_data_valid = 1'b1;
      sys_dout          = 16'(i);
      tick();
    end
    sys_dout = 16'd50;
    rst      = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (sys_cmd !== 2'b00 || owner !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_after: got cmd=%h owner=%0d busy=%b expected 0/0/0", sys_cmd, owner, busy); end
    checks++; if (fill_cnt !== 50) begin errors++; $display("FAIL rmid_fill_before: got %0d expected 50", fill_cnt); end
    for (int i = 0; i < 10; i++) tick();
    sys_rd_data_valid = 1'b0;
    checks++; if (fill_cnt !== 50) begin errors++; $display("FAIL rmid_no_strobe: got %0d expected 50", fill_cnt); end
    checks++; if (sys_cmd !== 2'b00 || state_dbg !== 2'd0) begin errors++; $display("FAIL rmid_idle: got cmd=%h state=%0d expected 0/0", sys_cmd, state_dbg); end
    tick();
  endtask

  task automatic test_restart();
    logic [1:0]  c;
    logic [22:0] a;
    logic        to;
    clear_counts();
    vid_low = 1'b1;
    serve(0, 0, c, a, to);
    checks++; if (to !== 1'b0 || a !== 23'h400000) begin errors++; $display("FAIL rst_first: got %h expected 400000", a); end
    serve(1, 5, c, a, to);
    checks++; if (to !== 1'b0 || a !== 23'h400008) begin errors++; $display("FAIL restart_inflight: got %h expected 400008", a); end
    serve(0, 0, c, a, to);
    vid_low = 1'b0;
    checks++; if (to !== 1'b0 || a !== 23'h400000) begin errors++; $display("FAIL restart_addr: got %h expected 400000", a); end
    tick();
    checks++; if (vqwe_cnt !== 24) begin errors++; $display("FAIL restart_vqwe: got %0d expected 24", vqwe_cnt); end
    checks++; if (dut.vid_ptr !== 19'd1) begin errors++; $display("FAIL restart_ptr: got %0d expected 1", dut.vid_ptr); end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b0;
    vid_low           = 1'b0;
    vid_restart       = 1'b0;
    cache_wr_req      = 1'b0;
    cache_waddr       = '0;
    cache_rd_req      = 1'b0;
    cache_raddr       = '0;
    sys_cmd_ack       = 2'b00;
    sys_rd_data_valid = 1'b0;
    sys_wr_data_valid = 1'b0;
    sys_dout          = '0;
    clear_counts();

    test_reset();
    test_video();
    test_back_to_back();
    test_starve();
    test_wrap();
    test_reset_mid();
    test_restart();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
